// File: rtl/decoder_pkg.sv
// Shared definitions for the scan decoder: FSM state encodings and a
// constant-foldable ceil(log2) helper used for counter sizing.
package decoder_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    DEC  = 2'd1,
    SCAN = 2'd2
  } state_t;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational binary-to-one-hot decoder; bit sel of onehot is set.
module onehot_decode #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a direct-decode mode and an auto-scan mode
// that steps the active output every SCAN_DIV cycles.
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [(1<<SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  tick,
  output logic [1:0]            dbg_state
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int PW    = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [OUT_W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic             tick_nxt;
  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] y_nxt;

  assign dbg_state = state;

  // The single decoder sees the index the outputs will hold next cycle.
  onehot_decode #(.SEL_W(SEL_W)) u_onehot_decode (
    .sel    (idx_nxt),
    .onehot (onehot)
  );

  assign y_nxt = (state_nxt == OFF) ? INACTIVE : (onehot ^ INACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      idx   <= '0;
      presc <= '0;
      tick  <= 1'b0;
      y     <= INACTIVE;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      presc <= presc_nxt;
      tick  <= tick_nxt;
      y     <= y_nxt;
    end
  end

  always_comb begin
    state_nxt = OFF;
    if (en) begin
      state_nxt = mode ? SCAN : DEC;
    end
  end

  // Entering SCAN from any other state reloads sel; position is never resumed.
  always_comb begin
    idx_nxt   = idx;
    presc_nxt = '0;
    tick_nxt  = 1'b0;
    case (state_nxt)
      DEC: begin
        idx_nxt = sel;
      end
      SCAN: begin
        if (state != SCAN) begin
          idx_nxt = sel;
        end else if (presc == PRE_LAST) begin
          idx_nxt  = idx + SEL_W'(1);
          tick_nxt = 1'b1;
        end else begin
          presc_nxt = presc + PW'(1);
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: three configurations driven together, directed
// scenarios followed by random traffic, checked against a cycle-level model.
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en;
  logic       mode;
  logic [1:0] sel_a;
  logic [2:0] sel_b;

  logic [3:0] y_a;
  logic [1:0] idx_a;
  logic       tick_a;
  logic [1:0] st_a;
  logic [7:0] y_b;
  logic [2:0] idx_b;
  logic       tick_b;
  logic [1:0] st_b;
  logic [3:0] y_c;
  logic [1:0] idx_c;
  logic       tick_c;
  logic [1:0] st_c;

  scan_decoder #(.SEL_W(2), .SCAN_DIV(4), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_a),
    .y(y_a), .idx(idx_a), .tick(tick_a), .dbg_state(st_a)
  );

  scan_decoder #(.SEL_W(3), .SCAN_DIV(3), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_b),
    .y(y_b), .idx(idx_b), .tick(tick_b), .dbg_state(st_b)
  );

  scan_decoder #(.SEL_W(2), .SCAN_DIV(1), .ACTIVE_LOW(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_a),
    .y(y_c), .idx(idx_c), .tick(tick_c), .dbg_state(st_c)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model per instance: mode (0 off, 1 decode, 2 scan), active index,
  // cycles elapsed since the last scan reload/advance, and tick.
  int m_sw[3]  = '{2, 3, 2};
  int m_div[3] = '{4, 3, 1};
  int m_al[3]  = '{0, 1, 0};
  int m_st[3]   = '{0, 0, 0};
  int m_idx[3]  = '{0, 0, 0};
  int m_cnt[3]  = '{0, 0, 0};
  int m_tick[3] = '{0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_y(input int k);
    logic [31:0] v;
    int n;
    n = 1 << m_sw[k];
    v = (m_st[k] == 0) ? 32'd0 : (32'd1 << m_idx[k]);
    if (m_al[k] != 0) v = v ^ ((32'd1 << n) - 32'd1);
    return v;
  endfunction

  task automatic model_edge();
    int s;
    for (int k = 0; k < 3; k++) begin
      s = (k == 1) ? int'(sel_b) : int'(sel_a);
      m_tick[k] = 0;
      if (rst) begin
        m_st[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
      end else if (!en) begin
        m_st[k] = 0; m_cnt[k] = 0;
      end else if (!mode) begin
        m_st[k] = 1; m_idx[k] = s; m_cnt[k] = 0;
      end else if (m_st[k] != 2) begin
        m_st[k] = 2; m_idx[k] = s; m_cnt[k] = 0;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == m_div[k]) begin
          m_idx[k]  = (m_idx[k] + 1) % (1 << m_sw[k]);
          m_cnt[k]  = 0;
          m_tick[k] = 1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("a_y",    32'(y_a),    model_y(0));
    chk("a_idx",  32'(idx_a),  32'(m_idx[0]));
    chk("a_tick", 32'(tick_a), 32'(m_tick[0]));
    chk("a_st",   32'(st_a),   32'(m_st[0]));
    chk("b_y",    32'(y_b),    model_y(1));
    chk("b_idx",  32'(idx_b),  32'(m_idx[1]));
    chk("b_tick", 32'(tick_b), 32'(m_tick[1]));
    chk("b_st",   32'(st_b),   32'(m_st[1]));
    chk("c_y",    32'(y_c),    model_y(2));
    chk("c_idx",  32'(idx_c),  32'(m_idx[2]));
    chk("c_tick", 32'(tick_c), 32'(m_tick[2]));
    chk("c_st",   32'(st_c),   32'(m_st[2]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_a = 2'd0; sel_b = 3'd0;
    step();
    chk("rst_a_y", 32'(y_a), 32'h0);
    chk("rst_b_y", 32'(y_b), 32'hFF);

    // Direct decode.
    rst = 1'b0; en = 1'b1; mode = 1'b0; sel_a = 2'd2; sel_b = 3'd5;
    step();
    chk("dec_y2",    32'(y_a),    32'b0100);
    chk("dec_idx2",  32'(idx_a),  32'd2);
    chk("dec_tick",  32'(tick_a), 32'd0);
    chk("pol_y5",    32'(y_b),    32'b11011111);
    sel_a = 2'd0;
    step();
    chk("dec_y0", 32'(y_a), 32'b0001);

    // Scan from 3 with wrap to 0, then advance to 1.
    mode = 1'b1; sel_a = 2'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("scan_hold_y", 32'(y_a), 32'b1000);
      chk("scan_hold_tick", 32'(tick_a), 32'd0);
    end
    step();
    chk("wrap_tick", 32'(tick_a), 32'd1);
    chk("wrap_idx",  32'(idx_a),  32'd0);
    chk("wrap_y",    32'(y_a),    32'b0001);
    for (int i = 0; i < 3; i++) step();
    step();
    chk("adv_tick", 32'(tick_a), 32'd1);
    chk("adv_idx",  32'(idx_a),  32'd1);

    // Single-cycle enable drop mid-scan.
    en = 1'b0; sel_a = 2'd2;
    step();
    chk("drop_y", 32'(y_a), 32'b0000);
    en = 1'b1;
    step();
    chk("reentry_y", 32'(y_a), 32'b0100);

    // Reset on the cycle a tick would occur.
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    chk("rst_scan_y",    32'(y_a),    32'h0);
    chk("rst_scan_idx",  32'(idx_a),  32'd0);
    chk("rst_scan_tick", 32'(tick_a), 32'd0);
    chk("rst_scan_b_y",  32'(y_b),    32'hFF);

    // SCAN_DIV = 1: advance every cycle after entry.
    rst = 1'b0; en = 1'b1; mode = 1'b1; sel_a = 2'd0;
    step();
    chk("fast_entry_idx",  32'(idx_c),  32'd0);
    chk("fast_entry_tick", 32'(tick_c), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("fast_idx",  32'(idx_c),  32'(i % 4));
      chk("fast_tick", 32'(tick_c), 32'd1);
    end

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 63) == 0);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      sel_a = 2'($urandom);
      sel_b = 3'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SEL_W, default 2: select width; decoder output count OUT_W = 2**SEL_W; legal range 1..5.
REQ-002 Parameter SCAN_DIV, default 4: clock cycles per scan step; legal range 1..65535.
REQ-003 Parameter ACTIVE_LOW, default 0: 1 inverts every bit of y so that active = 0.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  enable; 0 forces all outputs inactive.
REQ-008 mode  in  1  0 = direct decode, 1 = auto-scan.
REQ-009 sel  in  SEL_W  decode index (DEC) or scan start index (SCAN entry).
REQ-010 y  out  OUT_W  registered one-hot decode; polarity per ACTIVE_LOW.
REQ-011 idx  out  SEL_W  registered index of the active y bit.
REQ-012 tick  out  1  one-cycle pulse, aligned with the idx update, on every scan advance.

Function
REQ-013 Registered FSM states: OFF, DEC, SCAN. Next state is evaluated every cycle: !en -> OFF; en & !mode -> DEC; en & mode -> SCAN.
REQ-014 All outputs are registered; y, idx and tick reflect the inputs sampled on the previous rising edge (latency 1 cycle).
REQ-015 OFF: y inactive (all 0, or all 1 if ACTIVE_LOW); idx holds; tick = 0; prescaler cleared.
REQ-016 DEC: idx <= sel, bit sel of y active, all other bits inactive, tick = 0; a sel change is reflected one cycle later.
REQ-017 SCAN entry (previous state OFF or DEC): idx <= sel, prescaler <= 0, tick = 0, y = onehot(sel).
REQ-018 SCAN steady: prescaler counts 0..SCAN_DIV-1. The cycle it equals SCAN_DIV-1: idx <= idx+1 modulo 2**SEL_W, prescaler <= 0, tick <= 1, y follows the new idx. Otherwise tick <= 0. sel is ignored.
REQ-019 Wrap-around: idx = 2**SEL_W-1 advances to 0 with no extra cycle.
REQ-020 SCAN_DIV = 1: idx advances every cycle after entry; tick stays high continuously in steady SCAN.
REQ-021 Prescaler width = max(1, clog2(SCAN_DIV)); no overflow for any legal SCAN_DIV.
REQ-022 mode toggling SCAN->DEC->SCAN re-enters SCAN and reloads sel (REQ-017); scan position is not resumed.
REQ-023 en low for a single cycle in SCAN forces OFF for that cycle; the subsequent SCAN re-entry reloads sel.
REQ-024 y is exactly one-hot in DEC and SCAN, and all-inactive in OFF, with no exceptions.

Reset
REQ-025 rst sampled high sets state OFF, idx 0, prescaler 0, tick 0, y inactive (ACTIVE_LOW: all ones), effective on the next edge.
REQ-026 rst has priority over en, mode and sel, including mid-scan and simultaneously with a tick; tick is 0 in the cycle after reset.

Structure
REQ-027 Shared package decoder_pkg SHALL hold the FSM state encodings (OFF=2'd0, DEC=2'd1, SCAN=2'd2) and the clog2 helper function.
REQ-028 Sub-module onehot_decode (combinational, parameter SEL_W, in sel, out onehot) SHALL be instantiated once; polarity inversion and output registering stay in scan_decoder.

Verification
REQ-029 Decode (SEL_W=2): rst, then en=1, mode=0, sel=2 -> next cycle y=4'b0100, idx=2, tick=0; sel=0 -> one cycle later y=4'b0001.
REQ-030 Scan wrap (SEL_W=2, SCAN_DIV=4): en=1, mode=1, sel=3 -> y=4'b1000 for 4 cycles; then tick=1, idx=0, y=4'b0001; next tick after 4 more cycles gives idx=1.
REQ-031 Enable drop: en=0 for 1 cycle mid-scan at idx=1, sel=2 -> y=4'b0000 for 1 cycle; y=4'b0100 on re-entry.
REQ-032 Reset mid-scan: rst=1 in the same cycle a tick would occur -> next cycle y=4'b0000, idx=0, tick=0.
REQ-033 Polarity (SEL_W=3, ACTIVE_LOW=1): decode sel=5 -> y=8'b11011111; after rst -> y=8'hFF.
REQ-034 Fast scan (SEL_W=2, SCAN_DIV=1): scan from sel=0 -> idx steps 0,1,2,3,0 on consecutive cycles with tick held high after entry.
